key_cmd_scheduler: RTL and testbench

- Sits between kb_decoder (level outputs up/down/space) and the game control FSM.
- Turns key levels into discrete commands: press edges, auto-repeat for up/down, one-per-press space (flap).
- Arbitrates simultaneous events by fixed priority and delivers them one at a time over a valid/ready handshake.
- Holds one pending event per key, so short stalls lose nothing. Overflow beyond that is dropped and flagged.

---
 rtl/key_cmd_scheduler_if.sv | 22 ++
 rtl/key_cmd_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_key_cmd_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/key_cmd_scheduler_if.sv
// Command handshake between the key scheduler and the game control FSM.
// The producer drives cmd_valid/cmd_code/drop; the consumer drives cmd_ready.
interface key_cmd_scheduler_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic       drop;

  modport master (
    output cmd_valid,
    output cmd_code,
    output drop,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    input  drop,
    output cmd_ready
  );
endinterface

// File: rtl/key_cmd_scheduler.sv
// Turns up/down/space key levels into press and auto-repeat commands, queues one
// pending event per key and delivers them by fixed priority over valid/ready.
module key_cmd_scheduler #(
  parameter int CNT_W         = 25,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 up,
  input  logic                 down,
  input  logic                 space,
  key_cmd_scheduler_if.master  cmd
);

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_SPACE = 2;
  localparam int N_KEYS    = 3;

  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_UP    = 2'b01;
  localparam logic [1:0] CODE_DOWN  = 2'b10;
  localparam logic [1:0] CODE_SPACE = 2'b11;

  // The counter fires at LAST; reloading with DELAY-PERIOD spaces later repeats by PERIOD.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  logic [N_KEYS-1:0] keys_in;
  logic [N_KEYS-1:0] event_vec;

  assign keys_in = {space, down, up};

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      localparam bit CAN_REPEAT = (gi != KEY_SPACE);

      logic             s1_reg;
      logic             s2_reg;
      logic             key_press;
      logic             rpt;
      key_state_t       state_reg;
      key_state_t       state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= keys_in[gi];
          s2_reg    <= s1_reg;
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      assign key_press = s1_reg & ~s2_reg;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rpt        = 1'b0;
        if (!enable || !s1_reg) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              // A key already held (e.g. across an enable rise) waits for a fresh press.
              if (key_press) begin
                state_next = ST_HELD;
                cnt_next   = '0;
              end
            end
            ST_HELD: begin
              if (CAN_REPEAT) begin
                if (cnt_reg == CNT_LAST) begin
                  rpt        = 1'b1;
                  state_next = ST_REPEAT;
                  cnt_next   = CNT_RELOAD;
                end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
                end
              end
            end
            ST_REPEAT: begin
              if (cnt_reg == CNT_LAST) begin
                rpt      = 1'b1;
                cnt_next = CNT_RELOAD;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end
            default: begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      assign event_vec[gi] = enable & (key_press | rpt);
    end
  endgenerate

  logic [N_KEYS-1:0] pend_reg;
  logic [N_KEYS-1:0] pend_next;
  logic [N_KEYS-1:0] consume;
  logic              cmd_valid_reg;
  logic              cmd_valid_next;
  logic [1:0]        cmd_code_reg;
  logic [1:0]        cmd_code_next;
  logic              drop_reg;
  logic              drop_next;
  logic              load;

  assign load = ~cmd_valid_reg | cmd.cmd_ready;

  always_comb begin
    consume        = '0;
    cmd_valid_next = cmd_valid_reg;
    cmd_code_next  = cmd_code_reg;
    if (load) begin
      cmd_valid_next = 1'b0;
      cmd_code_next  = CODE_IDLE;
      // While disabled the stage only drains; pending flags are being flushed.
      if (enable) begin
        if (pend_reg[KEY_SPACE]) begin
          consume[KEY_SPACE] = 1'b1;
          cmd_valid_next     = 1'b1;
          cmd_code_next      = CODE_SPACE;
        end else if (pend_reg[KEY_UP]) begin
          consume[KEY_UP] = 1'b1;
          cmd_valid_next  = 1'b1;
          cmd_code_next   = CODE_UP;
        end else if (pend_reg[KEY_DOWN]) begin
          consume[KEY_DOWN] = 1'b1;
          cmd_valid_next    = 1'b1;
          cmd_code_next     = CODE_DOWN;
        end
      end
    end
  end

  always_comb begin
    pend_next = '0;
    drop_next = 1'b0;
    if (enable) begin
      pend_next = event_vec | (pend_reg & ~consume);
      // An event hitting a flag that stays set this edge has nowhere to go.
      drop_next = |(event_vec & pend_reg & ~consume);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_code_reg  <= CODE_IDLE;
      drop_reg      <= 1'b0;
    end else begin
      pend_reg      <= pend_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_code_reg  <= cmd_code_next;
      drop_reg      <= drop_next;
    end
  end

  assign cmd.cmd_valid = cmd_valid_reg;
  assign cmd.cmd_code  = cmd_code_reg;
  assign cmd.drop      = drop_reg;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with REPEAT_DELAY=8, REPEAT_PERIOD=4.
// Each check compares {drop, cmd_valid, cmd_code} against a hand-derived value.
module tb_key_cmd_scheduler;
  logic clk;
  logic rst_n;
  logic enable;
  logic up;
  logic down;
  logic space;
  int   errors;
  int   checks;

  key_cmd_scheduler_if cmd_if();

  key_cmd_scheduler #(
    .CNT_W        (25),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .up    (up),
    .down  (down),
    .space (space),
    .cmd   (cmd_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {cmd_if.drop, cmd_if.cmd_valid, cmd_if.cmd_code};
    checks++;
    $display("check %s: drop/valid/code=%b expected=%b", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    up = 1'b0;
    down = 1'b0;
    space = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    tick();
    tick();
    chk("reset", 4'b0000);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_after_reset", 4'b0000);

    // Single space press, held three cycles: one command, no repeat.
    space = 1'b1;
    tick(); chk("t1_e0", 4'b0000);
    tick(); chk("t1_e1", 4'b0000);
    tick(); chk("t1_e2", 4'b0111);
    space = 1'b0;
    tick(); chk("t1_e3", 4'b0000);
    for (int i = 4; i < 12; i++) begin
      tick(); chk($sformatf("t1_e%0d", i), 4'b0000);
    end

    // Up held for 20 cycles: UP after edges 2, 10, 14, 18 only.
    up = 1'b1;
    for (int e = 0; e < 26; e++) begin
      tick();
      if (e == 19) up = 1'b0;
      chk($sformatf("t2_e%0d", e),
          (e == 2 || e == 10 || e == 14 || e == 18) ? 4'b0101 : 4'b0000);
    end

    // Priority: all three rise together -> SPACE, UP, DOWN.
    up = 1'b1; down = 1'b1; space = 1'b1;
    tick(); chk("t3_e0", 4'b0000);
    tick(); chk("t3_e1", 4'b0000);
    tick(); chk("t3_e2", 4'b0111);
    up = 1'b0; down = 1'b0; space = 1'b0;
    tick(); chk("t3_e3", 4'b0101);
    tick(); chk("t3_e4", 4'b0110);
    tick(); chk("t3_e5", 4'b0000);
    tick(); chk("t3_e6", 4'b0000);
    tick(); tick();

    // Backpressure and overflow on DOWN.
    cmd_if.cmd_ready = 1'b0;
    down = 1'b1;
    tick(); chk("t4_e0", 4'b0000);
    down = 1'b0;
    tick(); chk("t4_e1", 4'b0000);
    tick(); chk("t4_e2", 4'b0110);
    tick(); chk("t4_e3", 4'b0110);
    down = 1'b1;
    tick();
    down = 1'b0;
    tick(); chk("t4_e5_pending", 4'b0110);
    tick(); chk("t4_e6", 4'b0110);
    down = 1'b1;
    tick();
    down = 1'b0;
    tick(); chk("t4_e8_drop", 4'b1110);
    tick(); chk("t4_e9_drop_end", 4'b0110);
    cmd_if.cmd_ready = 1'b1;
    tick(); chk("t4_e10_second", 4'b0110);
    tick(); chk("t4_e11_empty", 4'b0000);
    tick(); chk("t4_e12_empty", 4'b0000);
    tick(); tick();

    // Enable flush with an UP in the stage and another pending.
    cmd_if.cmd_ready = 1'b0;
    up = 1'b1;
    tick(); chk("t5_e0", 4'b0000);
    up = 1'b0;
    tick(); chk("t5_e1", 4'b0000);
    tick(); chk("t5_e2", 4'b0101);
    tick(); chk("t5_e3", 4'b0101);
    up = 1'b1;
    tick();
    up = 1'b0;
    tick(); chk("t5_e5_pending", 4'b0101);
    enable = 1'b0;
    down = 1'b1;
    tick(); chk("t5_e6_hold", 4'b0101);
    down = 1'b0;
    tick(); chk("t5_e7_hold", 4'b0101);
    cmd_if.cmd_ready = 1'b1;
    tick(); chk("t5_e8_drained", 4'b0000);
    tick(); chk("t5_e9", 4'b0000);
    enable = 1'b1;
    for (int i = 10; i < 14; i++) begin
      tick(); chk($sformatf("t5_e%0d_flushed", i), 4'b0000);
    end

    // Asynchronous reset while a command is valid; space stays held through release.
    cmd_if.cmd_ready = 1'b0;
    space = 1'b1;
    tick();
    tick();
    tick(); chk("t6_valid", 4'b0111);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", 4'b0000);
    tick(); chk("t6_in_reset", 4'b0000);
    rst_n = 1'b1;
    tick(); chk("t6_r0", 4'b0000);
    tick(); chk("t6_r1", 4'b0000);
    tick(); chk("t6_r2", 4'b0111);
    cmd_if.cmd_ready = 1'b1;
    tick(); chk("t6_r3", 4'b0000);
    tick(); chk("t6_r4", 4'b0000);
    tick(); chk("t6_r5", 4'b0000);
    space = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
